spectrum_bar_encoder: RTL and testbench



---
 rtl/spectrum_bar_encoder_if.sv | 42 ++++
 rtl/spectrum_bar_encoder.sv | 145 ++++++++++++++
 tb/tb_spectrum_bar_encoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spectrum_bar_encoder_if.sv
// Sample-stream and bar-output bundle between the FFT magnitude source and
// the spectrum bar encoder.
interface spectrum_bar_encoder_if #(
    parameter int unsigned MAG_W = 12
);
    logic             mag_valid;
    logic [1:0]       mag_bin;
    logic [MAG_W-1:0] mag;
    logic             frame_end;
    logic [15:0]      bin1;
    logic [15:0]      bin2;
    logic [15:0]      bin3;
    logic [15:0]      bin4;
    logic             bars_valid;
    logic             overrun;

    modport master (
        output mag_valid,
        output mag_bin,
        output mag,
        output frame_end,
        input  bin1,
        input  bin2,
        input  bin3,
        input  bin4,
        input  bars_valid,
        input  overrun
    );

    modport slave (
        input  mag_valid,
        input  mag_bin,
        input  mag,
        input  frame_end,
        output bin1,
        output bin2,
        output bin3,
        output bin4,
        output bars_valid,
        output overrun
    );
endinterface

// File: rtl/spectrum_bar_encoder.sv
// Per-frame peak tracking for 4 spectrum bins, quantised to 0..16 and shown as
// LSB-filled thermometer bars that rise instantly and fall one level per decay period.
module spectrum_bar_encoder #(
    parameter int unsigned MAG_W        = 12,
    parameter int unsigned NOISE_FLOOR  = 64,
    parameter int unsigned DECAY_FRAMES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    spectrum_bar_encoder_if.slave bus_io
);
    localparam int unsigned    CntW    = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DECAY_FRAMES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StUpd,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             bars_valid_q, bars_valid_d;
    logic             overrun_q, overrun_d;
    logic [MAG_W-1:0] peak_q [4];
    logic [MAG_W-1:0] peak_d [4];
    logic [MAG_W-1:0] snap_q [4];
    logic [MAG_W-1:0] snap_d [4];
    logic [4:0]       disp_q [4];
    logic [4:0]       disp_d [4];
    logic [15:0]      bin_q  [4];
    logic [15:0]      bin_d  [4];
    logic [4:0]       lvl;
    logic             dec;

    function automatic logic [4:0] quantise(input logic [MAG_W-1:0] snap);
        if (32'(snap) < NOISE_FLOOR) begin
            return 5'd0;
        end
        return {1'b0, snap[MAG_W-1 -: 4]} + 5'd1;
    endfunction

    function automatic logic [15:0] therm(input logic [4:0] level);
        logic [15:0] bar;
        for (int i = 0; i < 16; i++) begin
            bar[i] = (5'(i) < level);
        end
        return bar;
    endfunction

    assign dec = (cnt_q == CntLast);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        bars_valid_d = 1'b0;
        overrun_d    = overrun_q;
        peak_d       = peak_q;
        snap_d       = snap_q;
        disp_d       = disp_q;
        lvl          = quantise(snap_q[k_q]);

        for (int i = 0; i < 4; i++) begin
            if (bus_io.mag_valid && (bus_io.mag_bin == 2'(i)) && (bus_io.mag > peak_q[i])) begin
                peak_d[i] = bus_io.mag;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus_io.frame_end) begin
                    // A same-cycle sample lands in the snapshot; the new frame starts empty.
                    snap_d = peak_d;
                    for (int i = 0; i < 4; i++) begin
                        peak_d[i] = '0;
                    end
                    k_d     = 2'd0;
                    state_d = StUpd;
                end
            end
            StUpd: begin
                if (lvl >= disp_q[k_q]) begin
                    disp_d[k_q] = lvl;
                end else if (dec) begin
                    disp_d[k_q] = disp_q[k_q] - 5'd1;
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bars_valid_d = 1'b1;
                cnt_d        = dec ? '0 : cnt_q + CntW'(1);
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus_io.frame_end && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        for (int i = 0; i < 4; i++) begin
            bin_d[i] = therm(disp_q[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            k_q          <= 2'd0;
            cnt_q        <= '0;
            bars_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                peak_q[i] <= '0;
                snap_q[i] <= '0;
                disp_q[i] <= 5'd0;
                bin_q[i]  <= 16'h0000;
            end
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            bars_valid_q <= bars_valid_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < 4; i++) begin
                peak_q[i] <= peak_d[i];
                snap_q[i] <= snap_d[i];
                disp_q[i] <= disp_d[i];
                bin_q[i]  <= bin_d[i];
            end
        end
    end

    assign bus_io.bin1       = bin_q[0];
    assign bus_io.bin2       = bin_q[1];
    assign bus_io.bin3       = bin_q[2];
    assign bus_io.bin4       = bin_q[3];
    assign bus_io.bars_valid = bars_valid_q;
    assign bus_io.overrun    = overrun_q;
endmodule

// File: tb/tb_spectrum_bar_encoder.sv
// Directed bench for spectrum_bar_encoder: reset, rise, decay, same-cycle sample,
// overrun and mid-update reset, with hand-computed expected bars.
module tb_spectrum_bar_encoder;
    logic clk_i;
    logic rst_ni;
    int   checks;
    int   errors;
    int   pulses;

    spectrum_bar_encoder_if #(.MAG_W(12)) bus ();

    spectrum_bar_encoder #(
        .MAG_W        (12),
        .NOISE_FLOOR  (64),
        .DECAY_FRAMES (2)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus_io (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bins(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                            input logic [15:0] e3, input logic [15:0] e4);
        chk({tag, ".bin1"}, 32'(bus.bin1), 32'(e1));
        chk({tag, ".bin2"}, 32'(bus.bin2), 32'(e2));
        chk({tag, ".bin3"}, 32'(bus.bin3), 32'(e3));
        chk({tag, ".bin4"}, 32'(bus.bin4), 32'(e4));
    endtask

    task automatic sample(input logic [1:0] b, input logic [11:0] m);
        bus.mag_valid = 1'b1;
        bus.mag_bin   = b;
        bus.mag       = m;
        tick();
        bus.mag_valid = 1'b0;
    endtask

    task automatic fire_frame();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
    endtask

    // Leaves the bench in the cycle where bars_valid is high.
    task automatic wait_bars(input string tag);
        int n = 0;
        while (bus.bars_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".bars_valid"}, 32'(bus.bars_valid), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3, input logic [15:0] e4);
        fire_frame();
        wait_bars(tag);
        chk_bins(tag, e1, e2, e3, e4);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_ni        = 1'b0;
        bus.mag_valid = 1'b0;
        bus.mag_bin   = 2'd0;
        bus.mag       = 12'd0;
        bus.frame_end = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle.bars_valid", 32'(bus.bars_valid), 32'd0);
            chk("idle.overrun", 32'(bus.overrun), 32'd0);
        end
        chk_bins("idle", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Rise: levels 16, 2, 0, 4 with cycle-exact latency
        sample(2'd0, 12'd4095);
        sample(2'd1, 12'd300);
        sample(2'd2, 12'd63);
        sample(2'd3, 12'd1000);
        sample(2'd3, 12'd512);
        sample(2'd3, 12'd200);
        fire_frame();
        tick();
        chk("rise.t1.bin1", 32'(bus.bin1), 32'h0000);
        tick();
        chk("rise.t2.bin1", 32'(bus.bin1), 32'hFFFF);
        chk("rise.t2.bin2", 32'(bus.bin2), 32'h0000);
        tick();
        chk("rise.t3.bin2", 32'(bus.bin2), 32'h0003);
        chk("rise.t3.bars_valid", 32'(bus.bars_valid), 32'd0);
        tick();
        chk("rise.t4.bin4", 32'(bus.bin4), 32'h0000);
        chk("rise.t4.bars_valid", 32'(bus.bars_valid), 32'd0);
        tick();
        chk_bins("rise.t5", 16'hFFFF, 16'h0003, 16'h0000, 16'h000F);
        chk("rise.t5.bars_valid", 32'(bus.bars_valid), 32'd1);
        tick();
        chk("rise.t6.bars_valid", 32'(bus.bars_valid), 32'd0);

        // Refill bin1 on a decay frame so the next frame starts with frame_cnt = 0
        sample(2'd0, 12'd4095);
        run_frame("refill", 16'hFFFF, 16'h0001, 16'h0000, 16'h0007);

        // Decay with DECAY_FRAMES = 2: falls on every second empty frame
        run_frame("decay.f1", 16'hFFFF, 16'h0001, 16'h0000, 16'h0007);
        run_frame("decay.f2", 16'h7FFF, 16'h0000, 16'h0000, 16'h0003);
        run_frame("decay.f3", 16'h7FFF, 16'h0000, 16'h0000, 16'h0003);
        run_frame("decay.f4", 16'h3FFF, 16'h0000, 16'h0000, 16'h0001);

        // Same-cycle sample and frame_end
        bus.mag_valid = 1'b1;
        bus.mag_bin   = 2'd2;
        bus.mag       = 12'd2048;
        bus.frame_end = 1'b1;
        tick();
        bus.mag_valid = 1'b0;
        bus.frame_end = 1'b0;
        wait_bars("same");
        chk_bins("same", 16'h3FFF, 16'h0000, 16'h01FF, 16'h0001);
        run_frame("same.next", 16'h1FFF, 16'h0000, 16'h00FF, 16'h0000);
        chk("pre_overrun.overrun", 32'(bus.overrun), 32'd0);

        // Overrun: second frame_end two cycles after the first, with a sample
        fire_frame();
        tick();
        bus.frame_end = 1'b1;
        bus.mag_valid = 1'b1;
        bus.mag_bin   = 2'd1;
        bus.mag       = 12'd1024;
        tick();
        bus.frame_end = 1'b0;
        bus.mag_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.bars_valid === 1'b1) pulses++;
        end
        chk("overrun.pulses", 32'(pulses), 32'd1);
        chk("overrun.flag", 32'(bus.overrun), 32'd1);
        chk_bins("overrun.a", 16'h1FFF, 16'h0000, 16'h00FF, 16'h0000);
        run_frame("overrun.b", 16'h0FFF, 16'h001F, 16'h007F, 16'h0000);
        chk("overrun.sticky", 32'(bus.overrun), 32'd1);

        // Mid-update reset
        sample(2'd0, 12'd4095);
        fire_frame();
        tick();
        tick();
        chk("rst.t2.bin1", 32'(bus.bin1), 32'hFFFF);
        tick();
        rst_ni = 1'b0;
        #1;
        chk_bins("rst.now", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        chk("rst.now.bars_valid", 32'(bus.bars_valid), 32'd0);
        chk("rst.now.overrun", 32'(bus.overrun), 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.bars_valid === 1'b1) pulses++;
        end
        chk("rst.no_pulse", 32'(pulses), 32'd0);
        chk_bins("rst.after", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        sample(2'd3, 12'd4095);
        run_frame("rst.resume", 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
        chk("rst.resume.overrun", 32'(bus.overrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
